// File: rtl/mcu_pkg.sv
// mcu_pkg: shared definitions for the MCU SPI bridge.
//   - TGT_*        : default MCU target ids carried in byte 0 of a frame
//   - byte_idx_e   : position of the current byte within a frame
//   - target_e     : decoded target selected for the current frame
//   - target_strobe: one-hot strobe vector {sdc, osd, hid, sys} for a target
package mcu_pkg;

    localparam logic [7:0] TGT_SYS = 8'd1;
    localparam logic [7:0] TGT_HID = 8'd2;
    localparam logic [7:0] TGT_OSD = 8'd3;
    localparam logic [7:0] TGT_SDC = 8'd5;

    typedef enum logic [1:0] {
        IDX_TGT  = 2'd0,   // next byte is the target id
        IDX_CMD  = 2'd1,   // next byte is the command byte
        IDX_DATA = 2'd2    // every further byte is data
    } byte_idx_e;

    typedef enum logic [2:0] {
        SEL_NONE = 3'd0,
        SEL_SYS  = 3'd1,
        SEL_HID  = 3'd2,
        SEL_OSD  = 3'd3,
        SEL_SDC  = 3'd4
    } target_e;

    // Bit order of the returned vector: [0] sys, [1] hid, [2] osd, [3] sdc.
    function automatic logic [3:0] target_strobe(input target_e sel);
        case (sel)
            SEL_SYS: return 4'b0001;
            SEL_HID: return 4'b0010;
            SEL_OSD: return 4'b0100;
            SEL_SDC: return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: brings the asynchronous SPI pins into the clk domain.
// Ports:
//   clk        in  system clock
//   ss_pin     in  raw SPI select (active low)
//   sclk_pin   in  raw SPI clock
//   mosi_pin   in  raw MOSI
//   ss         out synchronised select level
//   ss_fall    out one-cycle pulse on synchronised select falling edge
//   sclk_rise  out one-cycle pulse on synchronised sclk rising edge
//   sclk_fall  out one-cycle pulse on synchronised sclk falling edge
//   mosi       out synchronised MOSI level (aligned with the sclk edges)
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic ss_pin,
    input  logic sclk_pin,
    input  logic mosi_pin,
    output logic ss,
    output logic ss_fall,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic mosi
);

    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   ss_prev;
    logic                   sclk_prev;

    // NOTE: the synchroniser and edge-history flops have no reset on purpose.
    // Resetting them to an idle value would make the real pin level look like
    // a fresh edge once reset is released (e.g. a phantom ss fall mid-frame).
    always_ff @(posedge clk) begin
        ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_pin};
        sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_pin};
        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_pin};
        ss_prev   <= ss_sync[SYNC_STAGES-1];
        sclk_prev <= sclk_sync[SYNC_STAGES-1];
    end

    assign ss        = ss_sync[SYNC_STAGES-1];
    assign mosi      = mosi_sync[SYNC_STAGES-1];
    assign ss_fall   = ss_prev & ~ss;
    assign sclk_rise = ~sclk_prev & sclk_sync[SYNC_STAGES-1];
    assign sclk_fall = sclk_prev & ~sclk_sync[SYNC_STAGES-1];

endmodule

// File: rtl/mcu_spi_bridge.sv
// mcu_spi_bridge: SPI mode-0 slave (MSB first) that routes MCU frames to one
// of four targets. Byte 0 selects the target, byte 1 is the command (strobed
// with mcu_start), later bytes are data. The selected target's data_out is
// shifted back on MISO one byte later.
// Ports:
//   clk, reset                        system clock, synchronous active-high reset
//   spi_io_ss/clk/din, spi_io_dout    SPI pins (ss active low, async inputs)
//   mcu_{sys,hid,osd,sdc}_strobe      one-cycle per-byte strobe to each target
//   mcu_start                         strobe is for the command byte
//   mcu_dout                          received byte, valid with a strobe
//   mcu_{sys,hid,osd,sdc}_din         target data_out returned to the MCU
module mcu_spi_bridge #(
    parameter logic [7:0] TGT_SYS     = mcu_pkg::TGT_SYS,
    parameter logic [7:0] TGT_HID     = mcu_pkg::TGT_HID,
    parameter logic [7:0] TGT_OSD     = mcu_pkg::TGT_OSD,
    parameter logic [7:0] TGT_SDC     = mcu_pkg::TGT_SDC,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_io_ss,
    input  logic       spi_io_clk,
    input  logic       spi_io_din,
    output logic       spi_io_dout,
    output logic       mcu_sys_strobe,
    output logic       mcu_hid_strobe,
    output logic       mcu_osd_strobe,
    output logic       mcu_sdc_strobe,
    output logic       mcu_start,
    output logic [7:0] mcu_dout,
    input  logic [7:0] mcu_sys_din,
    input  logic [7:0] mcu_hid_din,
    input  logic [7:0] mcu_osd_din,
    input  logic [7:0] mcu_sdc_din
);

    import mcu_pkg::*;

    logic      ss;
    logic      ss_fall;
    logic      sclk_rise;
    logic      sclk_fall;
    logic      mosi;

    logic      armed;       // set by an ss fall; only an armed frame is decoded
    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic [7:0] rx_next;
    logic [7:0] tx_shift;
    logic [7:0] tx_load;
    logic [1:0] load_pipe;  // byte_done delayed so the target can update din
    logic [3:0] strobe_q;
    logic      byte_done;
    target_e   target;
    target_e   rx_target;
    byte_idx_e byte_idx;
    byte_idx_e idx_next;

    spi_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_pin_sync (
        .clk       (clk),
        .ss_pin    (spi_io_ss),
        .sclk_pin  (spi_io_clk),
        .mosi_pin  (spi_io_din),
        .ss        (ss),
        .ss_fall   (ss_fall),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .mosi      (mosi)
    );

    assign rx_next   = {rx_shift[6:0], mosi};
    assign byte_done = armed & ~ss & sclk_rise & (bit_cnt == 3'd7);

    // NOTE: every always_comb output gets a default first, so no path through
    // the block can leave a signal unassigned and infer a latch.
    always_comb begin
        rx_target = SEL_NONE;
        if (rx_next == TGT_SYS)      rx_target = SEL_SYS;
        else if (rx_next == TGT_HID) rx_target = SEL_HID;
        else if (rx_next == TGT_OSD) rx_target = SEL_OSD;
        else if (rx_next == TGT_SDC) rx_target = SEL_SDC;
    end

    always_comb begin
        case (target)
            SEL_SYS: tx_load = mcu_sys_din;
            SEL_HID: tx_load = mcu_hid_din;
            SEL_OSD: tx_load = mcu_osd_din;
            SEL_SDC: tx_load = mcu_sdc_din;
            default: tx_load = 8'h00;
        endcase
    end

    // Frame position: restarts whenever the frame ends or was never armed,
    // and saturates at IDX_DATA.
    always_comb begin
        idx_next = byte_idx;
        if (ss || !armed) begin
            idx_next = IDX_TGT;
        end else if (byte_done) begin
            case (byte_idx)
                IDX_TGT: idx_next = IDX_CMD;
                default: idx_next = IDX_DATA;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) byte_idx <= IDX_TGT;
        else       byte_idx <= idx_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            armed       <= 1'b0;
            bit_cnt     <= 3'd0;
            rx_shift    <= 8'h00;
            tx_shift    <= 8'h00;
            load_pipe   <= 2'b00;
            target      <= SEL_NONE;
            strobe_q    <= 4'b0000;
            mcu_start   <= 1'b0;
            mcu_dout    <= 8'h00;
            spi_io_dout <= 1'b0;
        end else begin
            strobe_q  <= 4'b0000;
            mcu_start <= 1'b0;
            load_pipe <= {load_pipe[0], byte_done};

            if (ss) begin
                // Deselect wins over any sclk edge seen in the same cycle.
                armed       <= 1'b0;
                bit_cnt     <= 3'd0;
                target      <= SEL_NONE;
                load_pipe   <= 2'b00;
                spi_io_dout <= 1'b0;
            end else begin
                if (ss_fall) begin
                    armed       <= 1'b1;
                    tx_shift    <= 8'h00;
                    spi_io_dout <= 1'b0;
                end

                if (armed && sclk_rise) begin
                    rx_shift <= rx_next;
                    bit_cnt  <= bit_cnt + 3'd1;
                end

                if (byte_done) begin
                    if (byte_idx == IDX_TGT) begin
                        target <= rx_target;
                    end else if (target != SEL_NONE) begin
                        strobe_q  <= target_strobe(target);
                        mcu_start <= (byte_idx == IDX_CMD);
                        mcu_dout  <= rx_next;
                    end
                end

                // The fall that ends bit 7 (bit_cnt already wrapped to 0) must
                // not shift, or it would drop the MSB of the freshly loaded byte.
                if (armed && load_pipe[1]) begin
                    tx_shift    <= tx_load;
                    spi_io_dout <= tx_load[7];
                end else if (armed && sclk_fall && (bit_cnt != 3'd0)) begin
                    tx_shift    <= {tx_shift[6:0], 1'b0};
                    spi_io_dout <= tx_shift[6];
                end
            end
        end
    end

    assign mcu_sys_strobe = strobe_q[0];
    assign mcu_hid_strobe = strobe_q[1];
    assign mcu_osd_strobe = strobe_q[2];
    assign mcu_sdc_strobe = strobe_q[3];

endmodule

// File: tb/tb_mcu_spi_bridge.sv
// Directed bench for mcu_spi_bridge: drives SPI mode-0 frames at sclk = clk/8,
// records every strobe cycle and compares against hand-computed values.
module tb_mcu_spi_bridge;

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_ss;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso;
    logic       sys_stb, hid_stb, osd_stb, sdc_stb;
    logic       start;
    logic [7:0] dout;
    logic [7:0] sys_din;
    logic [7:0] hid_din = 8'hC3;
    logic [7:0] osd_din = 8'h3C;
    logic [7:0] sdc_din = 8'h99;

    int checks   = 0;
    int failures = 0;

    // One recorded strobe cycle: {sdc,osd,hid,sys}, start, byte.
    typedef struct packed {
        logic [3:0] stb;
        logic       start;
        logic [7:0] data;
    } ev_t;

    ev_t ev_q[$];

    always #5 clk = ~clk;

    mcu_spi_bridge dut (
        .clk            (clk),
        .reset          (reset),
        .spi_io_ss      (spi_ss),
        .spi_io_clk     (spi_sclk),
        .spi_io_din     (spi_mosi),
        .spi_io_dout    (spi_miso),
        .mcu_sys_strobe (sys_stb),
        .mcu_hid_strobe (hid_stb),
        .mcu_osd_strobe (osd_stb),
        .mcu_sdc_strobe (sdc_stb),
        .mcu_start      (start),
        .mcu_dout       (dout),
        .mcu_sys_din    (sys_din),
        .mcu_hid_din    (hid_din),
        .mcu_osd_din    (osd_din),
        .mcu_sdc_din    (sdc_din)
    );

    // Tiny sysctrl model: command 00 answers 5C, the next data byte answers 42.
    int sys_step;
    always @(posedge clk) begin
        if (reset) begin
            sys_din  <= 8'h00;
            sys_step <= 0;
        end else if (sys_stb && start) begin
            sys_din  <= (dout == 8'h00) ? 8'h5C : 8'hE0;
            sys_step <= 1;
        end else if (sys_stb) begin
            sys_din  <= (sys_step == 1) ? 8'h42 : 8'h00;
            sys_step <= 2;
        end
    end

    always @(negedge clk) begin
        if (sys_stb || hid_stb || osd_stb || sdc_stb)
            ev_q.push_back('{stb: {sdc_stb, osd_stb, hid_stb, sys_stb}, start: start, data: dout});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic ev_t ev_at(input int i);
        if (i < ev_q.size()) return ev_q[i];
        return '0;
    endfunction

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            spi_mosi = tx[7-i];
            repeat (4) @(negedge clk);
            rx = {rx[6:0], spi_miso};
            spi_sclk = 1'b1;
            repeat (4) @(negedge clk);
            spi_sclk = 1'b0;
        end
    endtask

    // Sends n bytes taken MSB-first from tx; MISO bytes come back in the same packing.
    task automatic frame(input logic [31:0] tx, input int n, output logic [31:0] rx);
        logic [7:0] b;
        rx = '0;
        spi_ss = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            spi_bits(tx[31-8*i -: 8], 8, b);
            rx[31-8*i -: 8] = b;
        end
        repeat (4) @(negedge clk);
        spi_ss = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rx;
        logic [7:0]  b;

        reset    = 1'b1;
        spi_ss   = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_strobes", {sdc_stb, osd_stb, hid_stb, sys_stb}, 4'b0000);
        check("rst_start", start, 1'b0);
        check("rst_dout", dout, 8'h00);
        check("rst_miso", spi_miso, 1'b0);

        // 1) sysctrl command 00
        ev_q.delete();
        frame(32'h0100AABB, 4, rx);
        check("t1_miso0", rx[31:24], 8'h00);
        check("t1_miso1", rx[23:16], 8'h00);
        check("t1_miso2", rx[15:8], 8'h5C);
        check("t1_miso3", rx[7:0], 8'h42);
        check("t1_count", ev_q.size(), 3);
        check("t1_ev0", ev_at(0), {4'b0001, 1'b1, 8'h00});

        // 2) command 04 'W' 01
        ev_q.delete();
        frame(32'h01045701, 4, rx);
        check("t2_count", ev_q.size(), 3);
        check("t2_ev0", ev_at(0), {4'b0001, 1'b1, 8'h04});
        check("t2_ev1", ev_at(1), {4'b0001, 1'b0, 8'h57});
        check("t2_ev2", ev_at(2), {4'b0001, 1'b0, 8'h01});

        // 3) unknown target
        ev_q.delete();
        frame(32'h07AABB00, 3, rx);
        check("t3_count", ev_q.size(), 0);
        check("t3_miso", rx, 32'h0);

        // 4) abort after 5 bits of the command byte, then a clean HID frame
        ev_q.delete();
        spi_ss = 1'b0;
        repeat (4) @(negedge clk);
        spi_bits(8'h01, 8, b);
        spi_bits(8'h77, 5, b);
        repeat (4) @(negedge clk);
        spi_ss = 1'b1;
        repeat (16) @(negedge clk);
        check("t4_abort_count", ev_q.size(), 0);
        frame(32'h0233AB00, 3, rx);
        check("t4_count", ev_q.size(), 2);
        check("t4_ev0", ev_at(0), {4'b0010, 1'b1, 8'h33});
        check("t4_miso1", rx[23:16], 8'hC3);

        // 5) reset mid-byte of an SDC frame
        ev_q.delete();
        spi_ss = 1'b0;
        repeat (4) @(negedge clk);
        spi_bits(8'h05, 8, b);
        spi_bits(8'h6A, 3, b);
        repeat (4) @(negedge clk);
        check("t5_miso_pre", spi_miso, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("t5_rst_strobes", {sdc_stb, osd_stb, hid_stb, sys_stb}, 4'b0000);
        check("t5_rst_start", start, 1'b0);
        check("t5_rst_dout", dout, 8'h00);
        check("t5_rst_miso", spi_miso, 1'b0);
        reset = 1'b0;
        spi_bits(8'hFF, 5, b);
        spi_bits(8'h22, 8, b);
        check("t5_unarmed_miso", b, 8'h00);
        repeat (4) @(negedge clk);
        spi_ss = 1'b1;
        repeat (16) @(negedge clk);
        check("t5_lost_count", ev_q.size(), 0);
        frame(32'h05110000, 2, rx);
        check("t5_count", ev_q.size(), 1);
        check("t5_ev0", ev_at(0), {4'b1000, 1'b1, 8'h11});

        // 6) back-to-back frames, ss high for 2 sclk periods between them
        ev_q.delete();
        frame(32'h03102030, 4, rx);
        check("t6_misoA", rx, 32'h003C3C3C);
        frame(32'h02405000, 3, rx);
        check("t6_misoB", rx, 32'h00C3C300);
        frame(32'h03600000, 2, rx);
        check("t6_count", ev_q.size(), 6);
        check("t6_ev0", ev_at(0), {4'b0100, 1'b1, 8'h10});
        check("t6_ev1", ev_at(1), {4'b0100, 1'b0, 8'h20});
        check("t6_ev2", ev_at(2), {4'b0100, 1'b0, 8'h30});
        check("t6_ev3", ev_at(3), {4'b0010, 1'b1, 8'h40});
        check("t6_ev4", ev_at(4), {4'b0010, 1'b0, 8'h50});
        check("t6_ev5", ev_at(5), {4'b0100, 1'b1, 8'h60});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
